// File: rtl/ecc_scrub_reader.sv
// Background SECDED scrubber: walks the memory in idle arbiter slots, decodes each
// 13-bit codeword, writes back single-bit corrections and logs double-bit errors.
module ecc_scrub_reader #(
    parameter int ADDR_W   = 4,
    parameter int INTERVAL = 16,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              r,
    input  logic              en,
    input  logic              mem_gnt,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [12:0]       mem_rdata,
    output logic [12:0]       mem_wdata,
    output logic              busy,
    output logic [CNT_W-1:0]  sec_cnt,
    output logic [CNT_W-1:0]  ded_cnt,
    output logic              ded_flag,
    output logic [ADDR_W-1:0] ded_addr,
    output logic              sweep_done,
    input  logic              clr
);

    localparam int IW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [IW-1:0] IVL_LOAD = IW'(INTERVAL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RD,
        S_DEC,
        S_WB,
        S_NEXT
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   ptr_reg, ptr_next;
    logic [IW-1:0]       ivl_reg, ivl_next;
    logic [12:0]         wdata_reg, wdata_next;
    logic [CNT_W-1:0]    sec_cnt_reg, ded_cnt_reg;
    logic                ded_flag_reg;
    logic [ADDR_W-1:0]   ded_addr_reg;
    logic                sec_inc, ded_inc;

    // Hamming positions that contribute to syndrome bit b
    function automatic logic [12:0] syn_mask(input int b);
        logic [12:0] m;
        m = '0;
        for (int k = 1; k < 13; k++) begin
            m[k] = (((k >> b) & 1) == 1);
        end
        return m;
    endfunction

    logic [3:0]  syn;
    logic        parity;
    logic        clean_hit, sec_hit;
    logic [12:0] corr_word;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_syn
            localparam logic [12:0] MASK = syn_mask(gi);
            assign syn[gi] = ^(mem_rdata & MASK);
        end
    endgenerate

    assign parity    = ^mem_rdata;
    assign clean_hit = (syn == 4'd0) && !parity;
    assign sec_hit   = parity && (syn <= 4'd12);
    // syndrome 0 with odd parity means bit 0 itself flipped, which the shift covers
    assign corr_word = mem_rdata ^ (13'd1 << syn);

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        ivl_next   = ivl_reg;
        wdata_next = wdata_reg;
        sec_inc    = 1'b0;
        ded_inc    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (en) begin
                    state_next = S_WAIT;
                    ivl_next   = IVL_LOAD;
                end
            end
            S_WAIT: begin
                if (!en) begin
                    state_next = S_IDLE;
                end else if (ivl_reg == '0) begin
                    state_next = S_RD;
                end else begin
                    ivl_next = ivl_reg - 1'b1;
                end
            end
            S_RD: begin
                if (mem_gnt) state_next = S_DEC;
            end
            S_DEC: begin
                if (sec_hit) begin
                    wdata_next = corr_word;
                    sec_inc    = 1'b1;
                    state_next = S_WB;
                end else begin
                    ded_inc    = !clean_hit;
                    state_next = S_NEXT;
                end
            end
            S_WB: begin
                if (mem_gnt) state_next = S_NEXT;
            end
            S_NEXT: begin
                ptr_next = ptr_reg + 1'b1;
                if (en) begin
                    state_next = S_WAIT;
                    ivl_next   = IVL_LOAD;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_reg    <= S_IDLE;
            ptr_reg      <= '0;
            ivl_reg      <= '0;
            wdata_reg    <= '0;
            sec_cnt_reg  <= '0;
            ded_cnt_reg  <= '0;
            ded_flag_reg <= 1'b0;
            ded_addr_reg <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            ivl_reg   <= ivl_next;
            wdata_reg <= wdata_next;
            if (clr) begin
                sec_cnt_reg  <= '0;
                ded_cnt_reg  <= '0;
                ded_flag_reg <= 1'b0;
                ded_addr_reg <= '0;
            end else begin
                if (sec_inc && (sec_cnt_reg != '1)) sec_cnt_reg <= sec_cnt_reg + 1'b1;
                if (ded_inc) begin
                    if (ded_cnt_reg != '1) ded_cnt_reg <= ded_cnt_reg + 1'b1;
                    ded_flag_reg <= 1'b1;
                    ded_addr_reg <= ptr_reg;
                end
            end
        end
    end

    // Strobes decode the state register and are qualified by the live grant so the
    // op lands in the granted cycle and read data is present during DEC.
    assign mem_re     = (state_reg == S_RD) && mem_gnt;
    assign mem_we     = (state_reg == S_WB) && mem_gnt;
    assign mem_addr   = ptr_reg;
    assign mem_wdata  = wdata_reg;
    assign busy       = (state_reg != S_IDLE) && (state_reg != S_WAIT);
    assign sweep_done = (state_reg == S_NEXT) && (&ptr_reg);
    assign sec_cnt    = sec_cnt_reg;
    assign ded_cnt    = ded_cnt_reg;
    assign ded_flag   = ded_flag_reg;
    assign ded_addr   = ded_addr_reg;

endmodule

// File: tb/tb_ecc_scrub_reader.sv
// Scoreboard bench for ecc_scrub_reader: a forked monitor pops expected reads/writes
// while directed phases inject upsets into a behavioural memory.
module tb_ecc_scrub_reader;
    localparam int AW  = 4;
    localparam int IVL = 16;
    localparam int CW  = 2;
    localparam int N   = 16;

    logic          clk = 1'b0;
    logic          r, en, mem_gnt, clr;
    logic          mem_re, mem_we, busy, ded_flag, sweep_done;
    logic [AW-1:0] mem_addr, ded_addr;
    logic [12:0]   mem_rdata = '0;
    logic [12:0]   mem_wdata;
    logic [CW-1:0] sec_cnt, ded_cnt;

    always #5 clk = ~clk;

    ecc_scrub_reader #(.ADDR_W(AW), .INTERVAL(IVL), .CNT_W(CW)) dut (
        .clk(clk), .r(r), .en(en), .mem_gnt(mem_gnt), .mem_re(mem_re), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .busy(busy),
        .sec_cnt(sec_cnt), .ded_cnt(ded_cnt), .ded_flag(ded_flag), .ded_addr(ded_addr),
        .sweep_done(sweep_done), .clr(clr)
    );

    logic [12:0] mem  [N];
    logic [12:0] gold [N];
    logic        load  = 1'b0;
    logic        inj_v = 1'b0;
    logic [3:0]  inj_a = '0;
    logic [12:0] inj_m = '0;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < N; i++) mem[i] <= gold[i];
        end else begin
            if (inj_v) mem[inj_a] <= mem[inj_a] ^ inj_m;
            if (mem_we) mem[mem_addr] <= mem_wdata;
        end
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          exp_rd [$];
    logic [16:0] exp_wr [$];
    int total = 0, bad = 0;
    int rd_count = 0, wr_count = 0, sd_count = 0, last_rd = -1, last_rd_addr = -1;
    bit spacing_on = 0;

    function automatic logic [12:0] enc(input logic [7:0] d);
        logic [12:0] c;
        c = '0;
        c[3] = d[0]; c[5] = d[1]; c[6] = d[2]; c[7] = d[3];
        c[9] = d[4]; c[10] = d[5]; c[11] = d[6]; c[12] = d[7];
        c[1] = c[3] ^ c[5] ^ c[7] ^ c[9] ^ c[11];
        c[2] = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11];
        c[4] = c[5] ^ c[6] ^ c[7] ^ c[12];
        c[8] = c[9] ^ c[10] ^ c[11] ^ c[12];
        c[0] = ^c[12:1];
        return c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic monitor();
        logic [16:0] w;
        forever begin
            @(negedge clk);
            if (!r) begin
                if (mem_re) begin
                    rd_count++;
                    $display("rd   addr=%0d cyc=%0d", mem_addr, cyc);
                    if (exp_rd.size() == 0) begin
                        total++; bad++;
                        $display("FAIL rd_unexpected: read of addr %0d, required no read", mem_addr);
                    end else begin
                        chk("rd_addr", 32'(mem_addr), 32'(exp_rd.pop_front()));
                    end
                    if (spacing_on && last_rd >= 0) chk("rd_spacing", 32'(cyc - last_rd), IVL + 3);
                    last_rd      = cyc;
                    last_rd_addr = 32'(mem_addr);
                end
                if (mem_we) begin
                    wr_count++;
                    $display("wr   addr=%0d data=%h", mem_addr, mem_wdata);
                    if (exp_wr.size() == 0) begin
                        total++; bad++;
                        $display("FAIL wr_unexpected: write of addr %0d, required no write", mem_addr);
                    end else begin
                        w = exp_wr.pop_front();
                        chk("wr_addr", 32'(mem_addr), 32'(w[16:13]));
                        chk("wr_data", 32'(mem_wdata), 32'(w[12:0]));
                    end
                end
                if (sweep_done) begin
                    sd_count++;
                    $display("sweep_done after addr=%0d", last_rd_addr);
                    chk("sweep_done_last_addr", 32'(last_rd_addr), N - 1);
                end
            end
        end
    endtask

    task automatic inject(input int a, input logic [12:0] m);
        @(posedge clk); #1;
        inj_a = 4'(a); inj_m = m; inj_v = 1'b1;
        @(posedge clk); #1;
        inj_v = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
    endtask

    task automatic push_wr(input int a);
        exp_wr.push_back({4'(a), gold[a]});
    endtask

    task automatic start_sweep(input bit space);
        for (int i = 0; i < N; i++) exp_rd.push_back(i);
        rd_count = 0; wr_count = 0; sd_count = 0; last_rd = -1;
        spacing_on = space;
        en = 1'b1;
    endtask

    task automatic finish_sweep(input string nm, input int nw);
        int n = 0;
        do begin
            @(negedge clk); n++;
        end while (!sweep_done && n < 4000);
        chk({nm, "_sweep_seen"}, 32'(sweep_done), 1);
        en = 1'b0;
        @(posedge clk); #1;
        spacing_on = 0;
        chk({nm, "_reads"}, rd_count, N);
        chk({nm, "_writes"}, wr_count, nw);
        chk({nm, "_sweep_pulses"}, sd_count, 1);
        chk({nm, "_rd_queue_left"}, exp_rd.size(), 0);
        chk({nm, "_wr_queue_left"}, exp_wr.size(), 0);
        chk({nm, "_busy_idle"}, 32'(busy), 0);
    endtask

    task automatic wait_read(input int a);
        int n = 0;
        do begin
            @(negedge clk); n++;
        end while (!(mem_re && 32'(mem_addr) == a) && n < 1000);
        chk("read_seen", 32'(mem_re), 1);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_re"}, 32'(mem_re), 0);
        chk({nm, "_we"}, 32'(mem_we), 0);
        chk({nm, "_addr"}, 32'(mem_addr), 0);
        chk({nm, "_wdata"}, 32'(mem_wdata), 0);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_sec"}, 32'(sec_cnt), 0);
        chk({nm, "_ded"}, 32'(ded_cnt), 0);
        chk({nm, "_dflag"}, 32'(ded_flag), 0);
        chk({nm, "_daddr"}, 32'(ded_addr), 0);
        chk({nm, "_sdone"}, 32'(sweep_done), 0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) gold[i] = enc(8'(i * 29 + 7));
        r = 1'b1; en = 1'b0; mem_gnt = 1'b0; clr = 1'b0; load = 1'b1;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        load = 1'b0; r = 1'b0; mem_gnt = 1'b1;

        // clean sweep with spacing check
        start_sweep(1);
        finish_sweep("clean", 0);
        chk("clean_sec", 32'(sec_cnt), 0);
        chk("clean_ded", 32'(ded_cnt), 0);

        // single data error, d3 at position 7 of addr 5
        inject(5, 13'h0080);
        push_wr(5);
        start_sweep(0);
        finish_sweep("sec_d3", 1);
        chk("sec_d3_cnt", 32'(sec_cnt), 1);
        chk("sec_d3_mem", 32'(mem[5]), 32'(gold[5]));
        pulse_clr();
        chk("clr_sec", 32'(sec_cnt), 0);

        // overall parity bit error at addr 2; addr 5 must now read clean
        inject(2, 13'h0001);
        push_wr(2);
        start_sweep(0);
        finish_sweep("sec_p0", 1);
        chk("sec_p0_cnt", 32'(sec_cnt), 1);
        chk("sec_p0_mem", 32'(mem[2]), 32'(gold[2]));

        // double error: positions 3 and 5 at addr 9
        inject(9, 13'h0028);
        start_sweep(0);
        finish_sweep("ded", 0);
        chk("ded_cnt", 32'(ded_cnt), 1);
        chk("ded_flag", 32'(ded_flag), 1);
        chk("ded_addr", 32'(ded_addr), 9);
        chk("ded_not_written", 32'(mem[9]), 32'(gold[9] ^ 13'h0028));
        pulse_clr();
        chk("clr_ded_cnt", 32'(ded_cnt), 0);
        chk("clr_ded_flag", 32'(ded_flag), 0);
        chk("clr_ded_addr", 32'(ded_addr), 0);
        inject(9, 13'h0028);

        // grant stall in RD and WB for addr 3 (position 10 flipped)
        inject(3, 13'h0400);
        push_wr(3);
        start_sweep(0);
        wait_read(2);
        @(posedge clk); #1 mem_gnt = 1'b0;
        for (int n = 0; n < 100 && busy; n++) begin @(posedge clk); #1; end
        for (int n = 0; n < 100 && !busy; n++) begin @(posedge clk); #1; end
        for (int i = 0; i < 10; i++) begin
            chk("stall_rd_re", 32'(mem_re), 0);
            chk("stall_rd_busy", 32'(busy), 1);
            @(posedge clk); #1;
        end
        chk("stall_rd_reads", rd_count, 3);
        mem_gnt = 1'b1;
        @(posedge clk); #1 mem_gnt = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            chk("stall_wb_we", 32'(mem_we), 0);
            chk("stall_wb_busy", 32'(busy), 1);
            @(posedge clk); #1;
        end
        chk("stall_wb_writes", wr_count, 0);
        mem_gnt = 1'b1;
        finish_sweep("stall", 1);
        chk("stall_mem", 32'(mem[3]), 32'(gold[3]));

        // reset asserted while a write-back is being strobed (addr 1, position 12)
        inject(1, 13'h1000);
        exp_rd.push_back(0);
        exp_rd.push_back(1);
        en = 1'b1;
        wait_read(1);
        @(posedge clk); #1 mem_gnt = 1'b0;
        @(posedge clk); #1;
        chk("wb_hold_we", 32'(mem_we), 0);
        mem_gnt = 1'b1;
        #1 chk("wb_we_before_reset", 32'(mem_we), 1);
        r = 1'b1;
        #1 check_zero("mid_wb_reset");
        en = 1'b0;
        @(posedge clk); #1;
        check_zero("held_reset");
        chk("reset_rd_queue", exp_rd.size(), 0);
        r = 1'b0;
        chk("reset_no_write", 32'(mem[1]), 32'(gold[1] ^ 13'h1000));

        // saturation: addr 1 still bad plus four more upsets
        inject(4, 13'h0002);
        inject(6, 13'h0004);
        inject(8, 13'h0010);
        inject(10, 13'h0100);
        push_wr(1); push_wr(4); push_wr(6); push_wr(8); push_wr(10);
        start_sweep(0);
        finish_sweep("sat", 5);
        chk("sat_sec_cnt", 32'(sec_cnt), 3);
        chk("sat_ded_cnt", 32'(ded_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
